// File: rtl/icache_pkg.sv
// Shared constants, address field slices and FSM state type for the
// direct-mapped read-only instruction cache.
package icache_pkg;

  localparam int ADDR_W          = 33;
  localparam int LINE_W          = 128;
  localparam int INDEX_W         = 6;
  localparam int LINES           = 1 << INDEX_W;
  localparam int BOOT_FILL_LINES = 2;

  // Byte address fields: offset [3:0], index [9:4], tag [32:10].
  localparam int OFFSET_MSB  = 3;
  localparam int OFFSET_LSB  = 0;
  localparam int INDEX_LSB   = OFFSET_MSB + 1;
  localparam int INDEX_MSB   = INDEX_LSB + INDEX_W - 1;
  localparam int TAG_LSB     = INDEX_MSB + 1;
  localparam int TAG_MSB     = ADDR_W - 1;
  localparam int TAG_W       = TAG_MSB - TAG_LSB + 1;
  localparam int LINE_ADDR_W = ADDR_W - INDEX_LSB;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_LOOKUP   = 3'd2,
    ST_MISS_REQ = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: registered read, single write port, and a
// synchronous clear of every valid bit.
module icache_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  // Read outputs hold between lookups so the owner sees a stable entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_valid <= 1'b0;
      rd_tag   <= '0;
      rd_data  <= '0;
    end else if (rd_en) begin
      rd_valid <= valid_q[rd_index];
      rd_tag   <= tag_mem[rd_index];
      rd_data  <= data_mem[rd_index];
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: boot warm-fill, then CPU line
// reads served from the array or refilled through a single-beat DMA request.
module icache
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_read_valid_i,
  output logic [LINE_W-1:0] ic_data_o,
  output logic [ADDR_W-1:0] ic_addr_o,
  output logic              cpu_read_ack_o,
  output logic [ADDR_W-1:0] ic_read_dma_addr_o,
  output logic              ic_read_dma_valid_o,
  input  logic              ic_read_dma_ack_i,
  input  logic [LINE_W-1:0] ic_read_dma_data_i,
  input  logic [ADDR_W-1:0] ic_read_addr_from_dma,
  output state_t            dbg_state
);

  // DMA handshake: a request (valid) is held with a stable address until an
  // accepted ack, i.e. ack=1 with a matching line address in the same cycle;
  // valid drops on the accepting edge. Mismatched or unsolicited acks are ignored.

  state_t                 state, next_state;
  logic [ADDR_W-1:0]      lat_addr;
  logic [LINE_ADDR_W-1:0] req_line;
  logic                   boot_req;
  logic                   dma_valid;
  logic                   dma_accept;
  logic                   hit;
  logic                   boot_last;
  logic                   rd_en;
  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [LINE_W-1:0]      rd_data;
  logic                   unused;

  assign dma_valid  = ((state == ST_BOOT) && boot_req) || (state == ST_MISS_REQ);
  assign dma_accept = dma_valid && ic_read_dma_ack_i &&
                      (ic_read_addr_from_dma[ADDR_W-1:INDEX_LSB] == req_line);
  assign hit        = rd_valid && (rd_tag == lat_addr[TAG_MSB:TAG_LSB]);
  assign boot_last  = (req_line == LINE_ADDR_W'(BOOT_FILL_LINES - 1));
  assign rd_en      = (state == ST_IDLE) && cpu_read_valid_i;
  assign unused     = ^ic_read_addr_from_dma[OFFSET_MSB:OFFSET_LSB];

  assign ic_read_dma_valid_o = dma_valid;
  assign ic_read_dma_addr_o  = {req_line, 4'h0};
  assign cpu_read_ack_o      = (state == ST_RESP);
  assign dbg_state           = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_BOOT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_BOOT:     if (dma_accept && boot_last) next_state = ST_IDLE;
      ST_IDLE:     if (cpu_read_valid_i) next_state = ST_LOOKUP;
      ST_LOOKUP:   next_state = hit ? ST_RESP : ST_MISS_REQ;
      ST_MISS_REQ: if (dma_accept) next_state = ST_RESP;
      ST_RESP:     next_state = ST_IDLE;
      default:     next_state = ST_BOOT;
    endcase
  end

  // req_line doubles as the boot line counter, starting at line 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_addr  <= '0;
      req_line  <= '0;
      boot_req  <= 1'b0;
      ic_data_o <= '0;
      ic_addr_o <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (dma_accept) begin
            boot_req <= 1'b0;
            req_line <= req_line + 1'b1;
          end else begin
            boot_req <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (cpu_read_valid_i) lat_addr <= cpu_addr_i;
        end
        ST_LOOKUP: begin
          if (hit) begin
            ic_data_o <= rd_data;
            ic_addr_o <= lat_addr;
          end else begin
            req_line <= lat_addr[ADDR_W-1:INDEX_LSB];
          end
        end
        ST_MISS_REQ: begin
          if (dma_accept) begin
            ic_data_o <= ic_read_dma_data_i;
            ic_addr_o <= lat_addr;
          end
        end
        default: ;
      endcase
    end
  end

  icache_array u_array (
    .clk      (clk),
    .clear    (!rst),
    .rd_en    (rd_en),
    .rd_index (cpu_addr_i[INDEX_MSB:INDEX_LSB]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (dma_accept),
    .wr_index (req_line[INDEX_W-1:0]),
    .wr_tag   (req_line[LINE_ADDR_W-1:INDEX_W]),
    .wr_data  (ic_read_dma_data_i)
  );

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed boot/hit/miss/reset steps followed by random
// reads, checked cycle by cycle against a line-residency model.
module tb_icache;
  import icache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_valid;
  logic [LINE_W-1:0] ic_data;
  logic [ADDR_W-1:0] ic_addr;
  logic              cpu_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_valid;
  logic              dma_ack;
  logic [LINE_W-1:0] dma_data;
  logic [ADDR_W-1:0] dma_from;
  state_t            dbg_state;

  int total = 0;
  int bad   = 0;
  logic [LINE_W-1:0] exp_q[$];

  // Model: which line address lives at each of the 64 slots, and its contents.
  logic              m_valid [64];
  logic [28:0]       m_line  [64];
  logic [LINE_W-1:0] m_data  [64];

  icache dut (
    .clk                   (clk),
    .rst                   (rst),
    .cpu_addr_i            (cpu_addr),
    .cpu_read_valid_i      (cpu_valid),
    .ic_data_o             (ic_data),
    .ic_addr_o             (ic_addr),
    .cpu_read_ack_o        (cpu_ack),
    .ic_read_dma_addr_o    (dma_addr),
    .ic_read_dma_valid_o   (dma_valid),
    .ic_read_dma_ack_i     (dma_ack),
    .ic_read_dma_data_i    (dma_data),
    .ic_read_addr_from_dma (dma_from),
    .dbg_state             (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [28:0] line, input logic [LINE_W-1:0] data);
    int slot;
    slot = int'(line % 64);
    m_valid[slot] = 1'b1;
    m_line[slot]  = line;
    m_data[slot]  = data;
  endtask

  // Expects the boot requests starting one edge after reset release.
  task automatic run_boot();
    for (int l = 0; l < BOOT_FILL_LINES; l++) begin
      tick();
      chk("boot_valid", dma_valid, 1);
      chk("boot_addr", dma_addr, LINE_W'(l * 16));
      chk("boot_no_cpu_ack", cpu_ack, 0);
      tick();
      chk("boot_hold", dma_valid, 1);
      dma_ack  = 1'b1;
      dma_from = ADDR_W'(l * 16);
      dma_data = '1;
      tick();
      dma_ack = 1'b0;
      chk("boot_drop", dma_valid, 0);
      model_fill(29'(l), '1);
    end
  endtask

  task automatic idle_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_no_ack"}, cpu_ack, 0);
      chk({tag, "_no_dma"}, dma_valid, 0);
      tick();
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] fill,
                         input int dly, input bit bad_first, input bit noise);
    logic [28:0]       line;
    int                slot;
    bit                is_hit;
    logic [LINE_W-1:0] exp;
    line   = addr[ADDR_W-1:4];
    slot   = int'(line % 64);
    is_hit = m_valid[slot] && (m_line[slot] == line);
    exp_q.push_back(is_hit ? m_data[slot] : fill);

    cpu_addr  = addr;
    cpu_valid = 1'b1;
    tick();
    cpu_valid = noise;
    chk("lookup_no_ack", cpu_ack, 0);
    chk("lookup_no_dma", dma_valid, 0);
    tick();
    if (!is_hit) begin
      chk("miss_valid", dma_valid, 1);
      chk("miss_addr", dma_addr, LINE_W'({line, 4'h0}));
      chk("miss_no_ack", cpu_ack, 0);
      for (int i = 0; i < dly; i++) begin
        tick();
        chk("miss_hold", dma_valid, 1);
        chk("miss_hold_addr", dma_addr, LINE_W'({line, 4'h0}));
      end
      if (bad_first) begin
        dma_ack  = 1'b1;
        dma_from = {line, 4'h0} ^ 33'h100;
        dma_data = ~fill;
        tick();
        dma_ack = 1'b0;
        chk("bad_ack_valid", dma_valid, 1);
        chk("bad_ack_no_cpu", cpu_ack, 0);
      end
      dma_ack  = 1'b1;
      dma_from = {line, 4'h0};
      dma_data = fill;
      tick();
      dma_ack = 1'b0;
      chk("refill_drop", dma_valid, 0);
      model_fill(line, fill);
    end else begin
      chk("hit_no_dma", dma_valid, 0);
    end
    chk("resp_ack", cpu_ack, 1);
    if (cpu_ack === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("resp_data", ic_data, exp);
      chk("resp_addr", ic_addr, LINE_W'(addr));
    end
    tick();
    cpu_valid = 1'b0;
    idle_quiet("post_resp");
  endtask

  initial begin
    rst       = 1'b0;
    cpu_addr  = '0;
    cpu_valid = 1'b0;
    dma_ack   = 1'b0;
    dma_data  = '0;
    dma_from  = '0;
    model_clear();

    tick();
    tick();
    chk("rst_state", LINE_W'(dbg_state), LINE_W'(ST_BOOT));
    chk("rst_dma_valid", dma_valid, 0);
    chk("rst_dma_addr", dma_addr, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_data", ic_data, 0);
    chk("rst_addr", ic_addr, 0);

    // CPU requests during boot must be ignored.
    cpu_valid = 1'b1;
    cpu_addr  = 33'h40;
    rst       = 1'b1;
    run_boot();
    cpu_valid = 1'b0;
    idle_quiet("after_boot");

    do_read(33'h0, '0, 0, 0, 0);
    do_read(33'd1024, 128'h1234, 1, 0, 0);
    do_read(33'h0, 128'habcd, 0, 0, 0);
    do_read(33'h400, 128'h5678, 1, 1, 1);

    // Reset while a refill is pending.
    cpu_addr  = 33'h800;
    cpu_valid = 1'b1;
    tick();
    cpu_valid = 1'b0;
    tick();
    chk("pend_valid", dma_valid, 1);
    rst = 1'b0;
    tick();
    chk("pend_rst_valid", dma_valid, 0);
    chk("pend_rst_ack", cpu_ack, 0);
    model_clear();
    rst = 1'b1;
    run_boot();
    idle_quiet("after_reboot");
    do_read(33'h1c, '0, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      a = (ADDR_W'($urandom_range(0, 3)) << 10) |
          (ADDR_W'($urandom_range(0, 3)) << 4) |
          ADDR_W'($urandom_range(0, 15));
      do_read(a, {$urandom(), $urandom(), $urandom(), $urandom()},
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk("exp_q_empty", LINE_W'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port and the DMA controller.
- Each line holds 128 bits (16 bytes); addresses are 33-bit byte addresses.
- Out of reset it warm-fills the first lines, then serves CPU reads.
- A hit returns a whole line; a miss triggers a single-beat DMA line refill before returning data.

Parameters:
- ADDR_W, 33, byte address width.
- LINE_W, 128, line/data width in bits; offset field is addr[3:0].
- INDEX_W, 6, index bits (64 lines, 1 KiB); index = addr[9:4], tag = addr[32:10].
- BOOT_FILL_LINES, 2, lines fetched after reset, at line addresses 0, 16, 32, ...

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- cpu_addr_i  in  33  CPU read byte address.
- cpu_read_valid_i  in  1  CPU read request; a single-cycle pulse is sufficient.
- ic_data_o  out  128  returned line, valid while cpu_read_ack_o=1.
- ic_addr_o  out  33  echoes the accepted CPU address, valid while cpu_read_ack_o=1.
- cpu_read_ack_o  out  1  one-cycle response pulse.
- ic_read_dma_addr_o  out  33  line-aligned refill address (low 4 bits = 0).
- ic_read_dma_valid_o  out  1  refill request, held until acked.
- ic_read_dma_ack_i  in  1  DMA completion; data returns in the same cycle.
- ic_read_dma_data_i  in  128  refill line.
- ic_read_addr_from_dma  in  33  address the DMA claims the returned data belongs to.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0 and all valid bits are cleared.
  - Any outstanding DMA request is dropped.
  - The FSM enters BOOT.
  - Reset mid-refill discards the partial state.
- States: BOOT, IDLE, LOOKUP, MISS_REQ, RESP.
- BOOT:
  - Issues BOOT_FILL_LINES sequential refills, at addresses 0, 16, ...
  - ic_read_dma_valid_o rises on the first edge after reset is released.
  - After each accepted ack, valid drops for one cycle, then the next request is issued.
  - After the last ack the FSM goes to IDLE.
  - CPU requests are ignored during BOOT.
- IDLE:
  - cpu_read_valid_i is sampled only here.
  - On 1, the address is latched and the FSM goes to LOOKUP.
  - Requests in any other state are dropped; the CPU re-issues if no ack arrives.
- LOOKUP: read the tag/valid/data array at the latched index.
  - Hit (valid and tag equal): go to RESP with the stored line.
  - Miss: go to MISS_REQ.
- MISS_REQ:
  - Drive ic_read_dma_valid_o=1 and ic_read_dma_addr_o={addr[32:4],4'h0}; hold both until an accepted ack.
  - Ack is accepted only when ic_read_dma_ack_i=1 and ic_read_addr_from_dma[32:4] equals the request line address.
  - On a mismatched ack the data is ignored and the request stays asserted.
  - On an accepted ack: write the data, set valid and the tag, capture the data for the response, drop valid on that same edge, go to RESP.
- RESP: cpu_read_ack_o=1 for exactly one cycle with ic_data_o and ic_addr_o; return to IDLE.
- Outputs in all other cycles: cpu_read_ack_o=0, ic_data_o and ic_addr_o hold their last values, ic_read_dma_valid_o=0.
- Latency, counting from the edge that samples the request:
  - Hit: ack is asserted in the 2nd following cycle.
  - Miss: DMA valid rises 2 cycles after sampling; the CPU ack follows 1 cycle after the accepted DMA ack.
- Ack and valid together in the first MISS_REQ cycle are legal: the refill completes in a single cycle.
- Conflict miss: the new line replaces the old one at the same index.
- ic_read_dma_ack_i outside MISS_REQ/BOOT request cycles is ignored.

Decomposition:
- Package icache_pkg holds:
  - ADDR_W and LINE_W constants.
  - The field-extraction slice constants (offset, index, tag).
  - The FSM state enum.
- One sub-module, icache_array: a synchronous-read tag/valid/data RAM with a single write port and a clear-all-valid input.

Test Plan:
- Reset then release, DMA acks each request one cycle after valid with data all-F -> requests at 0x0 then 0x10; valid deasserts after each ack; no cpu ack.
- After boot, CPU reads 0x0 -> hit; cpu_read_ack_o pulses 2 cycles later with ic_data_o all-F, ic_addr_o=0x0; no DMA request.
- CPU reads 1024 (index 0, tag 1) -> miss; DMA request with addr 0x400; ack with data 0x1234 -> cpu ack one cycle later, data 0x1234, ic_addr_o=1024. Then read 0x0 -> miss, refetches 0x0.
- DMA ack with ic_read_addr_from_dma=0x500 while the request is for 0x400 -> ignored; valid stays high; a correct ack completes the refill.
- Assert rst=0 while a DMA request is pending -> valid=0 next cycle; boot fill restarts at 0x0.
- CPU pulse during RESP/MISS_REQ -> no extra ack or DMA request.
